// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/WB control for an R-type datapath.
// Ports: clk, reset (async active-low), start/clear/n_instr run control;
//   imem_req/imem_ack/instr fetch handshake; pc_en/rf_en/rf_we/alu_func/ir datapath
//   controls; busy/done/illegal/retired status. Optional: `SEQ_TIMEOUT_EN` fetch timeout.
module cpu_sequencer #(
  parameter int CNT_W = 16,
  parameter int TMO_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic [CNT_W-1:0] n_instr,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      instr,
  output logic             pc_en,
  output logic             rf_en,
  output logic             rf_we,
  output logic [1:0]       alu_func,
  output logic [31:0]      ir,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] ret_inc;
  logic             dec_ok;
  logic [1:0]       dec_func;
  logic [5:0]       funct;

`ifdef SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo;
`else
  logic [TMO_W-1:0] unused_tmo;
  assign unused_tmo = '0;
`endif

  assign funct = ir[5:0];

  // Saturating increment of the retired count.
  assign ret_inc = (&retired) ? retired
                 : retired + {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    dec_ok   = (ir[31:26] == 6'd0);
    dec_func = 2'b00;
    unique case (1'b1)
      (funct == 6'h20): dec_func = 2'b00;
      (funct == 6'h22): dec_func = 2'b01;
      (funct == 6'h24): dec_func = 2'b10;
      (funct == 6'h25): dec_func = 2'b11;
      default:          dec_ok   = 1'b0;
    endcase
  end

  // Outputs are registered alongside the state so each reflects the
  // state being entered; nothing combinational reaches a port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      n_q      <= '0;
      imem_req <= 1'b0;
      pc_en    <= 1'b0;
      rf_en    <= 1'b0;
      rf_we    <= 1'b0;
      alu_func <= 2'b00;
      ir       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      retired  <= '0;
`ifdef SEQ_TIMEOUT_EN
      tmo      <= '0;
`endif
    end else begin
      done  <= 1'b0;
      pc_en <= 1'b0;
      rf_we <= 1'b0;
      if (clear) begin
        state    <= S_IDLE;
        imem_req <= 1'b0;
        rf_en    <= 1'b0;
        busy     <= 1'b0;
        illegal  <= 1'b0;
        retired  <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              n_q      <= n_instr;
              retired  <= '0;
              state    <= S_FETCH;
              imem_req <= 1'b1;
              busy     <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
              tmo      <= '0;
`endif
            end
          end
          S_FETCH: begin
            if (imem_ack) begin
              ir       <= instr;
              state    <= S_DECODE;
              imem_req <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            end else if (&tmo) begin
              illegal  <= 1'b1;
              state    <= S_HALT;
              imem_req <= 1'b0;
            end else begin
              tmo <= tmo + 1'b1;
`endif
            end
          end
          S_DECODE: begin
            if (dec_ok) begin
              alu_func <= dec_func;
              rf_en    <= 1'b1;
              state    <= S_EXEC;
            end else begin
              illegal <= 1'b1;
              state   <= S_HALT;
            end
          end
          S_EXEC: begin
            rf_we <= 1'b1;
            pc_en <= 1'b1;
            state <= S_WB;
          end
          S_WB: begin
            retired <= ret_inc;
            rf_en   <= 1'b0;
            if ((n_q != '0) && (ret_inc == n_q)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              imem_req <= 1'b1;
              state    <= S_FETCH;
`ifdef SEQ_TIMEOUT_EN
              tmo      <= '0;
`endif
            end
          end
          S_HALT: begin
            state <= S_HALT;
          end
          default: begin
            state    <= S_IDLE;
            imem_req <= 1'b0;
            rf_en    <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench for cpu_sequencer.
// A responder feeds instructions and pushes expected events; a monitor pops and compares.
module tb_cpu_sequencer;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic [CW-1:0] n_instr = '0;
  logic          imem_ack = 1'b0;
  logic [31:0]   instr = '0;
  logic          imem_req, pc_en, rf_en, rf_we, busy, done, illegal;
  logic [1:0]    alu_func;
  logic [31:0]   ir;
  logic [CW-1:0] retired;

  cpu_sequencer #(.CNT_W(CW), .TMO_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .n_instr(n_instr), .imem_req(imem_req), .imem_ack(imem_ack),
    .instr(instr), .pc_en(pc_en), .rf_en(rf_en), .rf_we(rf_we),
    .alu_func(alu_func), .ir(ir), .busy(busy), .done(done),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; logic [1:0] func; int cnt; } exp_t;
  typedef struct { logic [31:0] w; int d; } op_t;

  exp_t sb[$];
  op_t  prog[$];
  int   wb_cyc[$];
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, done_cyc = -1;
  int   m_ret = 0, m_n = 0, wait_cnt = 0;
  int   n_done = 0, n_ill = 0, n_pc = 0, n_we = 0, n_req = 0;
  logic ill_q = 1'b0;
  logic [5:0] fn_tab [4] = '{6'h20, 6'h22, 6'h24, 6'h25};
  logic [5:0] bad_tab [4] = '{6'h21, 6'h00, 6'h2a, 6'h08};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // Reference decode: legal R-type opcode and one of four functs.
  function automatic bit ref_dec(input logic [31:0] w, output logic [1:0] f);
    bit ok = 1'b1;
    f = 2'b00;
    case (w[5:0])
      6'h20: f = 2'd0;
      6'h22: f = 2'd1;
      6'h24: f = 2'd2;
      6'h25: f = 2'd3;
      default: ok = 1'b0;
    endcase
    if (w[31:26] != 6'd0) ok = 1'b0;
    return ok;
  endfunction

  // Model: each accepted word yields WB (and maybe DONE) or ILL.
  function automatic void issue(input logic [31:0] w);
    logic [1:0] f;
    if (ref_dec(w, f)) begin
      sb.push_back('{0, f, m_ret});
      m_ret++;
      if (m_n != 0 && m_ret == m_n) sb.push_back('{1, 2'b00, m_ret});
    end else begin
      sb.push_back('{2, 2'b00, m_ret});
    end
  endfunction

  function automatic void expect_ev(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_event", sb.size(), 1);
      return;
    end
    e = sb.pop_front();
    chk("ev_kind", e.kind, kind);
    chk("ev_retired", retired, e.cnt);
    if (kind == 0) begin
      chk("wb_alu_func", alu_func, e.func);
      chk("wb_strobes", {pc_en, rf_en}, 3);
    end
    if (kind == 1) chk("done_busy", busy, 0);
    if (kind == 2) chk("ill_busy", busy, 1);
  endfunction

  // Instruction memory responder with spurious acks outside FETCH.
  initial forever begin
    @(posedge clk); #1;
    imem_ack = 1'b0;
    if (imem_req && prog.size() > 0) begin
      if (wait_cnt < prog[0].d) wait_cnt++;
      else begin
        instr = prog[0].w;
        imem_ack = 1'b1;
        issue(prog[0].w);
        void'(prog.pop_front());
        wait_cnt = 0;
      end
    end else if (!imem_req && $urandom_range(0, 3) == 0) begin
      imem_ack = 1'b1;
      instr = $urandom;
    end
  end

  // Monitor.
  initial forever begin
    @(negedge clk);
    if (imem_req) n_req++;
    if (pc_en) n_pc++;
    if (rf_we) begin
      n_we++;
      wb_cyc.push_back(cyc);
      expect_ev(0);
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      expect_ev(1);
    end
    if (illegal && !ill_q) begin
      n_ill++;
      expect_ev(2);
    end
    ill_q = illegal;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_run(input int n, output int t0);
    tick();
    m_n = n;
    m_ret = 0;
    start = 1'b1;
    n_instr = CW'(n);
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input int lim);
    int d0 = n_done, i0 = n_ill, k = 0;
    while (n_done == d0 && n_ill == i0 && k < lim) begin
      tick();
      k++;
    end
    chk("run_end_timeout", k < lim, 1);
  endtask

  task automatic do_clear();
    prog.delete();
    wait_cnt = 0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_ret = 0;
    chk("clear_illegal", illegal, 0);
    chk("clear_busy", busy, 0);
    chk("clear_retired", retired, 0);
  endtask

  function automatic logic [31:0] legal_word();
    logic [31:0] w = $urandom;
    w[31:26] = 6'd0;
    w[5:0] = fn_tab[$urandom_range(0, 3)];
    return w;
  endfunction

  function automatic int wb_at(input int idx);
    if (idx < wb_cyc.size()) return wb_cyc[idx];
    return -1;
  endfunction

  initial begin
    int t0, b0, s0;
    logic [31:0] w;

    #12;
    chk("rst_strobes", {imem_req, pc_en, rf_en, rf_we, busy, done, illegal}, 0);
    chk("rst_ir", ir, 0);
    chk("rst_retired", retired, 0);
    chk("rst_alu_func", alu_func, 0);
    @(negedge clk);
    reset = 1'b1;

    // Two adds, zero-wait: WB at +4/+8, done at +9.
    prog.push_back('{32'h012A4020, 0});
    prog.push_back('{32'h012A4020, 0});
    b0 = wb_cyc.size();
    start_run(2, t0);
    chk("start_busy", busy, 1);
    chk("start_req", imem_req, 1);
    wait_end(100);
    chk("wb1_cycle", wb_at(b0) - t0, 4);
    chk("wb2_cycle", wb_at(b0 + 1) - t0, 8);
    chk("done_cycle", done_cyc - t0, 9);
    tick();
    chk("run1_retired", retired, 2);
    chk("run1_alu_func", alu_func, 0);
    chk("run1_done_pulse", done, 0);

    // sub / and / or, one pc_en each.
    prog.push_back('{32'h012A4022, 0});
    prog.push_back('{32'h012A4024, 1});
    prog.push_back('{32'h012A4025, 2});
    s0 = n_pc;
    start_run(3, t0);
    wait_end(100);
    chk("funct_pc_count", n_pc - s0, 3);

    // One-instruction run with 5-cycle ack delay.
    prog.push_back('{32'h012A4020, 5});
    s0 = n_req;
    b0 = wb_cyc.size();
    start_run(1, t0);
    wait_end(100);
    chk("delay_req_cycles", n_req - s0, 6);
    chk("delay_wb_cycle", wb_at(b0) - t0, 9);
    chk("delay_done_cycle", done_cyc - t0, 10);

    // Illegal opcode after one add.
    prog.push_back('{32'h012A4020, 0});
    prog.push_back('{32'h8C000000, 0});
    s0 = n_pc;
    b0 = n_we;
    start_run(3, t0);
    wait_end(100);
    repeat (3) tick();
    chk("halt_illegal", illegal, 1);
    chk("halt_busy", busy, 1);
    chk("halt_pc", n_pc - s0, 1);
    chk("halt_we", n_we - b0, 1);
    chk("halt_retired", retired, 1);
    do_clear();
    chk("drain_illegal", sb.size(), 0);

    // Open-ended run of 20 adds with a start pulse mid-run.
    for (int i = 0; i < 20; i++) prog.push_back('{legal_word() & 32'hFFFF_FFC0 | 32'h20, $urandom_range(0, 1)});
    b0 = n_we;
    s0 = n_done;
    start_run(0, t0);
    for (int k = 0; k < 400 && n_we < b0 + 20; k++) begin
      start = (k == 30);
      n_instr = (k == 30) ? CW'(10) : '0;
      tick();
    end
    start = 1'b0;
    repeat (3) tick();
    chk("open_retired", retired, 20);
    chk("open_busy", busy, 1);
    chk("open_req", imem_req, 1);
    chk("open_no_done", n_done - s0, 0);
    do_clear();
    chk("drain_open", sb.size(), 0);

    // Async reset during EXEC of a sub.
    prog.push_back('{32'h012A4022, 0});
    start_run(1, t0);
    for (int k = 0; k < 50 && !(rf_en && !rf_we); k++) tick();
    chk("exec_reached", rf_en && !rf_we, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_strobes", {imem_req, pc_en, rf_en, rf_we, busy, done, illegal}, 0);
    chk("arst_alu_func", alu_func, 0);
    chk("arst_ir", ir, 0);
    chk("arst_retired", retired, 0);
    sb.delete();
    prog.delete();
    wait_cnt = 0;
    @(negedge clk);
    reset = 1'b1;

    // clear together with start in IDLE.
    tick();
    clear = 1'b1;
    start = 1'b1;
    n_instr = CW'(1);
    tick();
    clear = 1'b0;
    start = 1'b0;
    chk("clr_start_busy", busy, 0);
    chk("clr_start_req", imem_req, 0);

    // Randomized runs.
    for (int r = 0; r < 15; r++) begin
      int n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 6) == 0) begin
          w = $urandom;
          if ($urandom_range(0, 1) == 1) begin
            w[31:26] = 6'd0;
            w[5:0] = bad_tab[$urandom_range(0, 3)];
          end else begin
            w[31:26] = 6'($urandom_range(1, 63));
          end
          prog.push_back('{w, $urandom_range(0, 3)});
          break;
        end
        prog.push_back('{legal_word(), $urandom_range(0, 3)});
      end
      start_run(n, t0);
      wait_end(300);
      tick();
      if (illegal) do_clear();
      chk("drain_random", sb.size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
